// File: rtl/alu181_slice_seq_if.sv
// Bus between the operand/control source, the nibble sequencer and the 4-bit ALU slice.
// The slave modport is the sequencer's view; the master modport is the surrounding environment.
interface alu181_slice_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   sel;
  logic         mode;
  logic         carry_in;
  logic [W-1:0] result;
  logic         carry_out;
  logic         a_eq_b;
  logic         busy;
  logic         done;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cin;
  logic [3:0]   alu_f;
  logic         alu_cout;
  logic         alu_eqv;

  modport slave (
    input  start, op_a, op_b, sel, mode, carry_in, alu_f, alu_cout, alu_eqv,
    output result, carry_out, a_eq_b, busy, done, alu_a, alu_b, alu_s, alu_m, alu_cin
  );

  modport master (
    output start, op_a, op_b, sel, mode, carry_in, alu_f, alu_cout, alu_eqv,
    input  result, carry_out, a_eq_b, busy, done, alu_a, alu_b, alu_s, alu_m, alu_cin
  );
endinterface

// File: rtl/alu181_slice_seq.sv
// Runs a 4*NIBBLES-bit operation through one 4-bit '181-style slice, LS nibble first,
// rippling the carry through a register and assembling the result one nibble per clock.
module alu181_slice_seq #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu181_slice_seq_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        r_state;
  logic [W-1:0]  r_sh_a;
  logic [W-1:0]  r_sh_b;
  logic [IW-1:0] r_idx;
  logic [3:0]    r_nib [NIBBLES];
  logic [3:0]    r_alu_s;
  logic          r_alu_m;
  logic          r_alu_cin;
  logic          r_carry_out;
  logic          r_a_eq_b;
  logic          r_eq_acc;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  w_result;
  logic          w_accept;
  logic          w_run;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_run    = (r_state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_idx       <= '0;
      r_alu_s     <= '0;
      r_alu_m     <= 1'b0;
      r_alu_cin   <= 1'b0;
      r_carry_out <= 1'b0;
      r_a_eq_b    <= 1'b0;
      r_eq_acc    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sh_a    <= bus.op_a;
            r_sh_b    <= bus.op_b;
            r_alu_s   <= bus.sel;
            r_alu_m   <= bus.mode;
            r_alu_cin <= bus.carry_in;
            r_idx     <= '0;
            r_eq_acc  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_alu_cin <= bus.alu_cout;
          r_eq_acc  <= r_eq_acc & bus.alu_eqv;
          r_sh_a    <= {4'h0, r_sh_a[W-1:4]};
          r_sh_b    <= {4'h0, r_sh_b[W-1:4]};
          r_idx     <= r_idx + IW'(1);
          if (r_idx == LAST) begin
            r_carry_out <= bus.alu_cout;
            r_a_eq_b    <= r_eq_acc & bus.alu_eqv;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle arms the pulse, second drops it and releases busy.
          if (!r_done) begin
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_nib[gi] <= 4'h0;
        end else if (w_accept) begin
          r_nib[gi] <= 4'h0;
        end else if (w_run && (r_idx == IW'(gi))) begin
          r_nib[gi] <= bus.alu_f;
        end
      end
      assign w_result[4*gi +: 4] = r_nib[gi];
    end
  endgenerate

  assign bus.alu_a     = r_sh_a[3:0];
  assign bus.alu_b     = r_sh_b[3:0];
  assign bus.alu_s     = r_alu_s;
  assign bus.alu_m     = r_alu_m;
  assign bus.alu_cin   = r_alu_cin;
  assign bus.result    = w_result;
  assign bus.carry_out = r_carry_out;
  assign bus.a_eq_b    = r_a_eq_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule
